// File: rtl/f51m_stream_stage.sv
// f51m_stream_stage
// Registered valid/ready wrapper around the combinational f51m core.
// The upstream side holds an accepted operand on op_data for one cycle. The
// core result is then captured into a small FIFO and offered downstream.
// Optional feature macro: F51M_STAGE_PARITY_EN. It adds a stored parity bit per
// entry and the out_par output.
module f51m_stream_stage #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   output logic [7:0]       op_data,
   input  logic [7:0]       res_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic [CNT_W-1:0] txn_count,
`ifdef F51M_STAGE_PARITY_EN
   output logic             out_par,
`endif
   output logic             busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
`ifdef F51M_STAGE_PARITY_EN
   localparam int EW = 9;
`else
   localparam int EW = 8;
`endif

   // Even parity over one result byte.
   function automatic logic par8(input logic [7:0] d);
      return ^d;
   endfunction

   logic [7:0]       op_data_r;
   logic             op_vld_r;
   logic [EW-1:0]    mem_r [0:DEPTH-1];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic [CNT_W-1:0] txn_count_r;

   logic [CW-1:0]    count_nxt_s;
   logic [CW:0]      occ_s;
   logic             nonempty_s;
   logic             in_ready_s;
   logic             accept_s;
   logic             push_s;
   logic             pop_s;
   logic [EW-1:0]    entry_s;
   logic [EW-1:0]    head_s;

   // Handshake decode. The in-flight operand reserves a FIFO slot, so
   // in_ready depends only on state and rst.
   always_comb begin
      occ_s      = {1'b0, count_r} + {{CW{1'b0}}, op_vld_r};
      nonempty_s = (count_r != {CW{1'b0}});
      if (rst) begin
         in_ready_s = 1'b0;
      end else begin
         in_ready_s = (occ_s < (CW+1)'(DEPTH));
      end
      accept_s = in_valid & in_ready_s;
      push_s   = op_vld_r;
      pop_s    = nonempty_s & out_ready;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Build the FIFO entry from the settled core result.
   always_comb begin
`ifdef F51M_STAGE_PARITY_EN
      entry_s = {par8(res_data), res_data};
`else
      entry_s = res_data;
`endif
   end

   // Operand register, FIFO pointers, occupancy and the transaction counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_data_r   <= 8'h00;
         op_vld_r    <= 1'b0;
         wr_ptr_r    <= {AW{1'b0}};
         rd_ptr_r    <= {AW{1'b0}};
         count_r     <= {CW{1'b0}};
         txn_count_r <= {CNT_W{1'b0}};
      end else begin
         if (accept_s) begin
            op_data_r <= in_data;
            op_vld_r  <= 1'b1;
         end else begin
            op_vld_r  <= 1'b0;
         end
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r    <= rd_ptr_r + AW'(1);
            txn_count_r <= txn_count_r + CNT_W'(1);
         end
         count_r <= count_nxt_s;
      end
   end

   // FIFO storage. It is not reset because empty entries are never presented.
   always_ff @(posedge clk) begin
      if (!rst && push_s) begin
         mem_r[wr_ptr_r] <= entry_s;
      end
   end

   // Head presentation. The outputs read as zero whenever the FIFO is empty.
   always_comb begin
      head_s = mem_r[rd_ptr_r];
      if (nonempty_s) begin
         out_data = head_s[7:0];
      end else begin
         out_data = 8'h00;
      end
`ifdef F51M_STAGE_PARITY_EN
      if (nonempty_s) begin
         out_par = head_s[8];
      end else begin
         out_par = 1'b0;
      end
`endif
   end

   assign in_ready  = in_ready_s;
   assign op_data   = op_data_r;
   assign out_valid = nonempty_s;
   assign txn_count = txn_count_r;
   assign busy      = op_vld_r | nonempty_s;

endmodule

// File: tb/tb_f51m_stream_stage.sv
// Testbench for f51m_stream_stage.
// The core is modelled as res_data = ~op_data. The reference model tracks
// accepted-but-not-popped results in a queue, together with each entry's
// acceptance edge. A second instance with CNT_W=4 exercises counter wrap.
// Build with F51M_STAGE_PARITY_EN defined to also check out_par.
module tb_f51m_stream_stage;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, out_ready;
   logic [7:0]  in_data;
   logic        in_ready, out_valid, busy;
   logic [7:0]  op_data, out_data, res_data;
   logic [15:0] txn_count;
   logic        in_ready2, out_valid2, busy2;
   logic [7:0]  op_data2, out_data2, res_data2;
   logic [3:0]  txn_count2;
`ifdef F51M_STAGE_PARITY_EN
   logic        out_par, out_par2;
`endif

   assign res_data  = ~op_data;
   assign res_data2 = ~op_data2;

   f51m_stream_stage #(.DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .op_data(op_data), .res_data(res_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .txn_count(txn_count),
`ifdef F51M_STAGE_PARITY_EN
      .out_par(out_par),
`endif
      .busy(busy)
   );

   f51m_stream_stage #(.DEPTH(DEPTH), .CNT_W(4)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data), .op_data(op_data2), .res_data(res_data2),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .txn_count(txn_count2),
`ifdef F51M_STAGE_PARITY_EN
      .out_par(out_par2),
`endif
      .busy(busy2)
   );

   typedef struct {
      logic [7:0] res;
      int         e;
   } ent_t;

   ent_t       mq[$];
   int         ecount = 0;
   int         pops = 0;
   logic [7:0] op_m = 8'h00;
   bit         live = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, check the current outputs against the model, then
   // advance both the DUTs and the model across one rising edge.
   task automatic step(input logic r, input logic v, input logic [7:0] d, input logic ordy);
      logic       exp_rdy, exp_ov;
      logic [7:0] exp_od;
      bit         acc, pop;
      ent_t       e;
      rst = r; in_valid = v; in_data = d; out_ready = ordy;
      #1;
      exp_rdy = !r && (mq.size() < DEPTH);
      exp_ov  = (mq.size() > 0) && (mq[0].e < ecount);
      exp_od  = exp_ov ? mq[0].res : 8'h00;
      if (live) begin
         check_eq("in_ready",   {31'd0, in_ready},   {31'd0, exp_rdy});
         check_eq("op_data",    {24'd0, op_data},    {24'd0, op_m});
         check_eq("out_valid",  {31'd0, out_valid},  {31'd0, exp_ov});
         check_eq("out_data",   {24'd0, out_data},   {24'd0, exp_od});
         check_eq("busy",       {31'd0, busy},       {31'd0, (mq.size() != 0)});
         check_eq("txn_count",  {16'd0, txn_count},  pops & 32'hFFFF);
         check_eq("in_ready2",  {31'd0, in_ready2},  {31'd0, exp_rdy});
         check_eq("out_data2",  {24'd0, out_data2},  {24'd0, exp_od});
         check_eq("out_valid2", {31'd0, out_valid2}, {31'd0, exp_ov});
         check_eq("busy2",      {31'd0, busy2},      {31'd0, (mq.size() != 0)});
         check_eq("txn_count2", {28'd0, txn_count2}, pops & 32'hF);
`ifdef F51M_STAGE_PARITY_EN
         check_eq("out_par",    {31'd0, out_par},    {31'd0, ^exp_od});
         check_eq("out_par2",   {31'd0, out_par2},   {31'd0, ^exp_od});
`endif
      end else if (r) begin
         check_eq("in_ready_rst", {31'd0, in_ready}, 32'd0);
      end
      acc = v && exp_rdy;
      pop = exp_ov && ordy;
      @(posedge clk);
      ecount++;
      if (r) begin
         mq.delete();
         pops = 0;
         op_m = 8'h00;
         live = 1'b1;
      end else begin
         if (pop) begin
            void'(mq.pop_front());
            pops++;
         end
         if (acc) begin
            e.res = ~d;
            e.e   = ecount;
            mq.push_back(e);
            op_m  = d;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      // Reset hold with an eager upstream.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hFF, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Single transaction, popped after a short wait.
      step(1'b0, 1'b1, 8'hA5, 1'b0);
      step(1'b0, 1'b0, 8'h11, 1'b0);
      step(1'b0, 1'b0, 8'h22, 1'b0);
      step(1'b0, 1'b0, 8'h33, 1'b1);
      check_eq("single_cnt", {16'd0, txn_count}, 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Streaming at full rate.
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, i[7:0], 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
      check_eq("stream_cnt", {16'd0, txn_count}, 32'd17);

      // Backpressure: fill, hold, then drain.
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h40 + i[7:0], 1'b0);
      check_eq("bp_ready", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
      check_eq("bp_cnt", {16'd0, txn_count}, 32'd21);

      // Reset mid-operation with three queued entries and one in flight.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h60 + i[7:0], 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 8'h3C, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      check_eq("post_rst_head", {24'd0, out_data}, 32'hC3);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

      // Parity corner values: results 0x5A and 0x5B.
      step(1'b0, 1'b1, 8'hA5, 1'b1);
      step(1'b0, 1'b1, 8'hA4, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(63) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(9) < 7) ? 1'b1 : 1'b0,
              8'($urandom),
              ($urandom_range(9) < 6) ? 1'b1 : 1'b0);
      end
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
